// File: rtl/register_input_pipe.sv
// Elastic multi-stage operand register for the LUT multiplier path: valid/ready
// flow with bubble collapse, per-lane zero masking, sync flush and occupancy count.
module register_input_pipe #(
  parameter  int DIM_A       = 4,
  parameter  int INPUT_WIDTH = 8,
  parameter  int DEPTH       = 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIM_A-1:0]             in_mask,
  input  logic [DIM_A*INPUT_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DIM_A*INPUT_WIDTH-1:0] out_data,
  output logic [CW-1:0]                occupancy
);

  localparam int W = DIM_A * INPUT_WIDTH;

  logic [DEPTH-1:0] vld_p;
  logic [W-1:0]     data_p [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [W-1:0]     masked;
  logic             accept;
  logic             leave;

  // Ready chain: a stage may load when it is empty or its occupant moves on.
  always_comb begin
    logic a;
    a = out_ready | ~vld_p[DEPTH-1];
    adv[DEPTH-1] = a;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      a = a | ~vld_p[k];
      adv[k] = a;
    end
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < DIM_A; i++) begin
      if (in_mask[i]) masked[i*INPUT_WIDTH +: INPUT_WIDTH] = in_data[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign accept    = in_valid & in_ready;
  assign leave     = vld_p[DEPTH-1] & out_ready & ~flush;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // Stage k boundary: stage 0 takes the masked input, later stages take k-1.
    if (k == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p[0]  <= 1'b0;
          data_p[0] <= '0;
        end else if (flush) begin
          vld_p[0]  <= 1'b0;
          data_p[0] <= '0;
        end else if (adv[0]) begin
          vld_p[0]  <= accept;
          data_p[0] <= masked;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p[k]  <= 1'b0;
          data_p[k] <= '0;
        end else if (flush) begin
          vld_p[k]  <= 1'b0;
          data_p[k] <= '0;
        end else if (adv[k]) begin
          vld_p[k]  <= vld_p[k-1];
          data_p[k] <= data_p[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     occupancy <= '0;
    else if (flush) occupancy <= '0;
    else            occupancy <= occupancy + CW'(accept) - CW'(leave);
  end

endmodule

// File: tb/tb_register_input_pipe.sv
// Bench for register_input_pipe: directed scenarios plus random traffic against a
// queue-of-beats reference model that tracks each beat's stage position.
module tb_register_input_pipe;

  localparam int DIM_A = 4;
  localparam int IW    = 8;
  localparam int DEPTH = 2;
  localparam int W     = DIM_A * IW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DIM_A-1:0] in_mask;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  int           q_pos[$];
  logic [W-1:0] q_dat[$];
  logic [W-1:0] delivered[$];

  always #5 clk = ~clk;

  register_input_pipe #(.DIM_A(DIM_A), .INPUT_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] d, input logic [DIM_A-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM_A; i++) if (m[i]) r[i*IW +: IW] = d[i*IW +: IW];
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input logic [IW-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < DIM_A; i++) r[i*IW +: IW] = b;
    return r;
  endfunction

  // One clock: starts just after a negedge, compares against the model, ends at the next negedge.
  task automatic cycle(input logic iv, input logic [DIM_A-1:0] m, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    int np[$];
    int lim;
    int p;
    logic exp_ov, exp_ir;
    in_valid = iv; in_mask = m; in_data = d; out_ready = ordy; flush = fl;
    #1;
    lim = ordy ? DEPTH : DEPTH - 1;
    foreach (q_pos[i]) begin
      p = (q_pos[i] + 1 <= lim) ? q_pos[i] + 1 : q_pos[i];
      np.push_back(p);
      lim = p - 1;
    end
    exp_ov = (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
    exp_ir = !fl && !((np.size() > 0) && (np[np.size()-1] == 0));
    checks++;
    if (out_valid !== exp_ov) begin
      errors++; $display("FAIL out_valid: got %0b expected %0b at %0t", out_valid, exp_ov, $time);
    end
    checks++;
    if (occupancy !== CW'(q_pos.size())) begin
      errors++; $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, q_pos.size(), $time);
    end
    checks++;
    if (in_ready !== exp_ir) begin
      errors++; $display("FAIL in_ready: got %0b expected %0b at %0t", in_ready, exp_ir, $time);
    end
    if (exp_ov) begin
      checks++;
      if (out_data !== q_dat[0]) begin
        errors++; $display("FAIL out_data: got %h expected %h at %0t", out_data, q_dat[0], $time);
      end
    end
    @(posedge clk);
    if (fl) begin
      q_pos.delete(); q_dat.delete();
    end else begin
      q_pos = np;
      while (q_pos.size() > 0 && q_pos[0] == DEPTH) begin
        delivered.push_back(q_dat[0]);
        void'(q_pos.pop_front()); void'(q_dat.pop_front());
      end
      if (iv && exp_ir) begin
        q_pos.push_back(0); q_dat.push_back(apply_mask(d, m));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '1, '0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mask = '1; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got ov=%0b od=%h occ=%0d ir=%0b expected 0,0,0,1",
               out_valid, out_data, occupancy, in_ready);
    end
    rst_n = 1'b1;
    q_pos.delete(); q_dat.delete();
    idle_cycles(1, 1'b1);
  endtask

  task automatic test_stream();
    int first_out;
    delivered.delete();
    first_out = -1;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, '1, splat(IW'(i)), 1'b1, 1'b0);
      if (first_out < 0 && delivered.size() > 0) first_out = i;
    end
    idle_cycles(DEPTH + 1, 1'b1);
    checks++;
    if (first_out !== DEPTH + 1) begin
      errors++; $display("FAIL stream_latency: got first out in cycle %0d expected %0d", first_out, DEPTH + 1);
    end
    checks++;
    if (delivered.size() !== 16) begin
      errors++; $display("FAIL stream_count: got %0d expected 16", delivered.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (delivered[i] !== splat(IW'(i + 1))) begin
          errors++; $display("FAIL stream_order[%0d]: got %h expected %h", i, delivered[i], splat(IW'(i + 1)));
        end
      end
    end
  endtask

  task automatic test_fill();
    cycle(1'b1, '1, splat(8'hA1), 1'b0, 1'b0);
    cycle(1'b1, '1, splat(8'hA2), 1'b0, 1'b0);
    cycle(1'b1, '1, splat(8'hA3), 1'b0, 1'b0);
    checks++;
    if (occupancy !== CW'(2) || in_ready !== 1'b0 || out_data !== splat(8'hA1)) begin
      errors++;
      $display("FAIL fill_full: got occ=%0d ir=%0b od=%h expected 2,0,%h", occupancy, in_ready, out_data, splat(8'hA1));
    end
    delivered.delete();
    cycle(1'b1, '1, splat(8'hA3), 1'b1, 1'b0);
    idle_cycles(4, 1'b1);
    checks++;
    if (delivered.size() !== 3 || delivered[2] !== splat(8'hA3)) begin
      errors++; $display("FAIL fill_release: got %0d beats expected 3 ending in a3", delivered.size());
    end
  endtask

  task automatic test_mask();
    cycle(1'b1, 4'b0101, splat(8'hFF), 1'b1, 1'b0);
    idle_cycles(DEPTH - 1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00FF_00FF) begin
      errors++; $display("FAIL mask_lanes: got ov=%0b od=%h expected 1,00ff00ff", out_valid, out_data);
    end
    idle_cycles(2, 1'b1);
  endtask

  task automatic test_bubble();
    cycle(1'b1, '1, splat(8'h3A), 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    cycle(1'b1, '1, splat(8'h3B), 1'b0, 1'b0);
    checks++;
    if (occupancy !== CW'(2) || out_data !== splat(8'h3A)) begin
      errors++; $display("FAIL bubble_compact: got occ=%0d od=%h expected 2,%h", occupancy, out_data, splat(8'h3A));
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, '1, splat(8'h55), 1'b1, 1'b1);
    checks++;
    if (occupancy !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL flush_clear: got occ=%0d ov=%0b od=%h expected 0,0,0", occupancy, out_valid, out_data);
    end
    idle_cycles(DEPTH + 1, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, '1, splat(IW'(8'hC0 + i)), 1'b1, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got ov=%0b od=%h occ=%0d ir=%0b expected 0,0,0,1", out_valid, out_data, occupancy, in_ready);
    end
    #1 rst_n = 1'b1;
    q_pos.delete(); q_dat.delete();
    @(negedge clk);
    for (int i = 0; i < 6; i++) cycle(1'b1, '1, splat(IW'(8'hD0 + i)), 1'b1, 1'b0);
    idle_cycles(DEPTH + 1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 65), DIM_A'($urandom), W'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 4));
    end
    idle_cycles(DEPTH + 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_mask();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
